// File: rtl/sram_wb_bytelane_ctrl_if.sv
// Wishbone classic slave-side bundle between the interconnect and the SRAM controller.
// Pure wiring: no storage, no latency.
// Backpressure is expressed only through ack/err; the master holds stb/cyc until one arrives.
interface sram_wb_bytelane_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   logic                  wbs_stb_i;
   logic                  wbs_cyc_i;
   logic                  wbs_we_i;
   logic [SEL_WIDTH-1:0]  wbs_sel_i;
   logic [DATA_WIDTH-1:0] wbs_dat_i;
   logic [31:0]           wbs_adr_i;
   logic                  wbs_ack_o;
   logic                  wbs_err_o;
   logic [DATA_WIDTH-1:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_err_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_err_o, wbs_dat_o
   );
endinterface

// File: rtl/sram_wb_bytelane_ctrl.sv
// Wishbone classic slave for a 1W/1R SRAM macro with windowed decode and byte lanes via read-modify-write.
// Latency (edges incl. accept): read RL+2, full write 2, partial write RL+3, error/empty write 1.
// One transfer at a time; no request accepted until back in IDLE; dropping cyc aborts a pending read phase.
module sram_wb_bytelane_ctrl #(
   parameter int          DATA_WIDTH   = 32,
   parameter int          ADDR_WIDTH   = 10,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   sram_wb_bytelane_ctrl_if.slave wb,
   output logic                  csb0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   output logic                  csb1,
   output logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] dout1,
   output logic                  busy_o
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP
   } state_t;

   state_t                state;
   logic [1:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [SEL_WIDTH-1:0]  sel_q;
   logic [DATA_WIDTH-1:0] dat_q;

   logic                  req;
   logic                  in_range;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic                  wait_done;
   logic [DATA_WIDTH-1:0] merged;
   logic                  unused_adr_bits;

   assign req             = wb.wbs_stb_i & wb.wbs_cyc_i;
   assign in_range        = wb.wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
   assign req_idx         = wb.wbs_adr_i[ADDR_WIDTH+1:2];
   assign unused_adr_bits = ^wb.wbs_adr_i[1:0];
   assign wait_done       = wait_cnt == 2'(READ_LATENCY - 1);
   assign busy_o          = state != IDLE;

   // Unselected lanes keep what the SRAM currently holds.
   always_comb begin
      merged = dout1;
      for (int i = 0; i < SEL_WIDTH; i++) begin
         if (sel_q[i]) merged[8*i +: 8] = dat_q[8*i +: 8];
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         idx_q        <= '0;
         sel_q        <= '0;
         dat_q        <= '0;
         wb.wbs_ack_o <= 1'b0;
         wb.wbs_err_o <= 1'b0;
         wb.wbs_dat_o <= '0;
         csb0         <= 1'b1;
         addr0        <= '0;
         din0         <= '0;
         csb1         <= 1'b1;
         addr1        <= '0;
      end else begin
         // Strobes are single-cycle unless a state re-asserts them below.
         wb.wbs_ack_o <= 1'b0;
         wb.wbs_err_o <= 1'b0;
         csb0         <= 1'b1;
         csb1         <= 1'b1;
         case (state)
            IDLE: begin
               if (req) begin
                  idx_q <= req_idx;
                  sel_q <= wb.wbs_sel_i;
                  dat_q <= wb.wbs_dat_i;
                  if (!in_range) begin
                     wb.wbs_err_o <= 1'b1;
                     wb.wbs_dat_o <= '0;
                     state        <= RESP;
                  end else if (wb.wbs_we_i && wb.wbs_sel_i == '0) begin
                     wb.wbs_ack_o <= 1'b1;
                     state        <= RESP;
                  end else if (!wb.wbs_we_i) begin
                     csb1  <= 1'b0;
                     addr1 <= req_idx;
                     state <= RD;
                  end else if (&wb.wbs_sel_i) begin
                     csb0  <= 1'b0;
                     addr0 <= req_idx;
                     din0  <= wb.wbs_dat_i;
                     state <= WR;
                  end else begin
                     csb1  <= 1'b0;
                     addr1 <= req_idx;
                     state <= RMW_RD;
                  end
               end
            end
            RD, RMW_RD: begin
               wait_cnt <= '0;
               if (!wb.wbs_cyc_i)  state <= IDLE;
               else if (state == RD) state <= RD_WAIT;
               else                state <= RMW_WAIT;
            end
            RD_WAIT: begin
               if (!wb.wbs_cyc_i) begin
                  state <= IDLE;
               end else if (wait_done) begin
                  wb.wbs_dat_o <= dout1;
                  wb.wbs_ack_o <= 1'b1;
                  state        <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            RMW_WAIT: begin
               if (!wb.wbs_cyc_i) begin
                  state <= IDLE;
               end else if (wait_done) begin
                  csb0  <= 1'b0;
                  addr0 <= idx_q;
                  din0  <= merged;
                  state <= RMW_WR;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            // The SRAM write has already been issued; finish regardless of cyc.
            WR, RMW_WR: begin
               wb.wbs_ack_o <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sram_wb_bytelane_ctrl.sv
// Directed bench for sram_wb_bytelane_ctrl: one instance with READ_LATENCY=1, one with 3.
// Behavioural SRAM models drive dout1 only in the single cycle before the controller's capture edge.
module tb_sram_wb_bytelane_ctrl;
   localparam int          DW   = 32;
   localparam int          AW   = 10;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] GARB = 32'hBAD0_0BAD;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        stb, cyc, we, use_b;
   logic [3:0]  sel;
   logic [31:0] dat, adr;

   int checks   = 0;
   int failures = 0;

   sram_wb_bytelane_ctrl_if #(.DATA_WIDTH(DW)) ifa ();
   sram_wb_bytelane_ctrl_if #(.DATA_WIDTH(DW)) ifb ();

   assign ifa.wbs_stb_i = stb & ~use_b;
   assign ifa.wbs_cyc_i = cyc & ~use_b;
   assign ifa.wbs_we_i  = we;
   assign ifa.wbs_sel_i = sel;
   assign ifa.wbs_dat_i = dat;
   assign ifa.wbs_adr_i = adr;
   assign ifb.wbs_stb_i = stb & use_b;
   assign ifb.wbs_cyc_i = cyc & use_b;
   assign ifb.wbs_we_i  = we;
   assign ifb.wbs_sel_i = sel;
   assign ifb.wbs_dat_i = dat;
   assign ifb.wbs_adr_i = adr;

   logic          csb0_a, csb1_a, busy_a, csb0_b, csb1_b, busy_b;
   logic [AW-1:0] addr0_a, addr1_a, addr0_b, addr1_b;
   logic [DW-1:0] din0_a, dout1_a, din0_b, dout1_b;

   sram_wb_bytelane_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .BASE_ADDR(BASE)) dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb(ifa.slave),
      .csb0(csb0_a), .addr0(addr0_a), .din0(din0_a),
      .csb1(csb1_a), .addr1(addr1_a), .dout1(dout1_a), .busy_o(busy_a)
   );

   sram_wb_bytelane_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3), .BASE_ADDR(BASE)) dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb(ifb.slave),
      .csb0(csb0_b), .addr0(addr0_b), .din0(din0_b),
      .csb1(csb1_b), .addr1(addr1_b), .dout1(dout1_b), .busy_o(busy_b)
   );

   logic [DW-1:0] mem_a [1024];
   logic [DW-1:0] mem_b [1024];
   logic [DW-1:0] pipe_a [1];
   logic [DW-1:0] pipe_b [3];

   always @(posedge clk) begin
      if (!csb0_a) mem_a[addr0_a] <= din0_a;
      pipe_a[0] <= !csb1_a ? mem_a[addr1_a] : GARB;
      if (!csb0_b) mem_b[addr0_b] <= din0_b;
      pipe_b[0] <= !csb1_b ? mem_b[addr1_b] : GARB;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign dout1_a = pipe_a[0];
   assign dout1_b = pipe_b[2];

   // Observation muxed onto whichever instance is currently being exercised.
   logic          ack, err, c0, c1, busy;
   logic [DW-1:0] rd, din0_o;
   logic [AW-1:0] a0, a1;
   assign ack    = use_b ? ifb.wbs_ack_o : ifa.wbs_ack_o;
   assign err    = use_b ? ifb.wbs_err_o : ifa.wbs_err_o;
   assign rd     = use_b ? ifb.wbs_dat_o : ifa.wbs_dat_o;
   assign c0     = use_b ? csb0_b : csb0_a;
   assign c1     = use_b ? csb1_b : csb1_a;
   assign busy   = use_b ? busy_b : busy_a;
   assign din0_o = use_b ? din0_b : din0_a;
   assign a0     = use_b ? addr0_b : addr0_a;
   assign a1     = use_b ? addr1_b : addr1_a;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   int            e, n0, n1;
   logic [31:0]   ld;
   logic [AW-1:0] la0, la1;
   logic          ge, ga, aft;

   // Runs one transfer; edges counts the accept edge as 1 up to the edge that makes ack/err visible.
   task automatic xfer(input logic w, input logic [3:0] s, input logic [31:0] d, input logic [31:0] a,
                       output int edges, output int n_c0, output int n_c1,
                       output logic [31:0] last_din, output logic [AW-1:0] last_a0,
                       output logic [AW-1:0] last_a1, output logic got_err,
                       output logic got_ack, output logic after);
      we = w; sel = s; dat = d; adr = a; stb = 1'b1; cyc = 1'b1;
      n_c0 = 0; n_c1 = 0; last_din = '0; last_a0 = '0; last_a1 = '0;
      got_err = 1'b0; got_ack = 1'b0;
      @(posedge clk);
      edges = 1;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (!c0) begin n_c0++; last_din = din0_o; last_a0 = a0; end
         if (!c1) begin n_c1++; last_a1 = a1; end
         if (ack || err) begin got_err = err; got_ack = ack; break; end
         @(posedge clk);
         edges++;
      end
      stb = 1'b0; cyc = 1'b0;
      @(posedge clk);
      #1;
      after = ack | err | busy;
   endtask

   logic [31:0] exp_w [8];
   int          k;

   initial begin
      stb = 0; cyc = 0; we = 0; sel = 0; dat = 0; adr = 0; use_b = 0;
      rst = 1'b1;
      #12;
      chk("reset_strobes", {ack, err, c0, c1, busy}, {1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      chk("reset_dat_o", rd, 32'h0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      xfer(1, 4'hF, 32'hDEAD_BEEF, BASE + 32'h10, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("fullwr_latency", e, 2);
      chk("fullwr_ports", {n0[7:0], n1[7:0]}, {8'd1, 8'd0});
      chk("fullwr_addr0", la0, 4);
      chk("fullwr_din0", ld, 32'hDEAD_BEEF);
      chk("fullwr_resp_one_cycle", aft, 0);

      xfer(0, 4'hF, 32'h0, BASE + 32'h10, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("read_latency", e, 3);
      chk("read_ports", {n0[7:0], n1[7:0]}, {8'd0, 8'd1});
      chk("read_addr1", la1, 4);
      chk("read_data", rd, 32'hDEAD_BEEF);

      xfer(1, 4'hF, 32'h1122_3344, BASE + 32'h10, e, n0, n1, ld, la0, la1, ge, ga, aft);
      xfer(1, 4'b0101, 32'hAABB_CCDD, BASE + 32'h10, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("rmw_latency", e, 4);
      chk("rmw_ports", {n0[7:0], n1[7:0]}, {8'd1, 8'd1});
      chk("rmw_din0", ld, 32'h11BB_33DD);
      chk("rmw_ack_not_err", {ga, ge}, {1'b1, 1'b0});
      // Low address bits and sel are ignored for reads.
      xfer(0, 4'h0, 32'h0, BASE + 32'h13, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("rmw_readback", rd, 32'h11BB_33DD);

      xfer(0, 4'hF, 32'h0, BASE + (32'h1 << (AW + 2)), e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("err_flags", {ge, ga}, {1'b1, 1'b0});
      chk("err_latency", e, 1);
      chk("err_no_sram", n0 + n1, 0);
      chk("err_dat_zero", rd, 32'h0);
      chk("err_resp_one_cycle", aft, 0);

      xfer(1, 4'h0, 32'h0, BASE + 32'h10, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("sel0_latency", e, 1);
      chk("sel0_ack", {ga, ge}, {1'b1, 1'b0});
      chk("sel0_no_sram", n0 + n1, 0);

      // Abort a partial write while it waits on read data.
      we = 1; sel = 4'b1000; dat = 32'hFF00_0000; adr = BASE + 32'h10; stb = 1; cyc = 1;
      @(posedge clk); #1;
      chk("abort_rmw_rd", c1, 0);
      @(posedge clk); #1;
      chk("abort_in_wait", {busy, c1}, {1'b1, 1'b1});
      stb = 0; cyc = 0;
      @(posedge clk); #1;
      chk("abort_busy_fall", busy, 0);
      n0 = 0; ga = 0;
      repeat (4) begin
         if (!c0) n0++;
         if (ack | err) ga = 1'b1;
         @(posedge clk); #1;
      end
      chk("abort_no_write", n0, 0);
      chk("abort_no_resp", ga, 0);
      xfer(0, 4'hF, 32'h0, BASE + 32'h10, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("abort_mem_unchanged", rd, 32'h11BB_33DD);

      // Reset in the middle of a read.
      we = 0; sel = 4'hF; adr = BASE + 32'h10; stb = 1; cyc = 1;
      @(posedge clk); #1;
      chk("midrd_in_rd", c1, 0);
      rst = 1'b1;
      #1;
      chk("midrd_reset_strobes", {ack, err, c0, c1, busy}, {1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      chk("midrd_reset_dat", rd, 32'h0);
      stb = 0; cyc = 0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         exp_w[i] = 32'h0101_0101 * (i + 1);
         xfer(1, 4'hF, exp_w[i], BASE + 4 * i, e, n0, n1, ld, la0, la1, ge, ga, aft);
      end

      // Back-to-back reads with stb/cyc held; the address advances on each ack.
      k = 0; we = 0; sel = 4'hF; adr = BASE; stb = 1; cyc = 1;
      for (int cy = 0; cy < 100 && k < 8; cy++) begin
         @(posedge clk); #1;
         if (ack) begin
            chk("b2b_data", rd, exp_w[k]);
            k++;
            adr = BASE + 4 * k;
            if (k == 8) begin stb = 0; cyc = 0; end
            @(posedge clk); #1;
            chk("b2b_idle_after_ack", {ack, busy}, 2'b00);
         end
      end
      chk("b2b_ack_count", k, 8);
      ga = 0;
      repeat (5) begin @(posedge clk); #1; if (ack | err) ga = 1'b1; end
      chk("b2b_no_extra_ack", ga, 0);

      use_b = 1;
      @(posedge clk); #1;
      xfer(1, 4'hF, 32'hCAFE_F00D, BASE + 32'h8, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("rl3_fullwr_latency", e, 2);
      xfer(0, 4'hF, 32'h0, BASE + 32'h8, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("rl3_read_latency", e, 5);
      chk("rl3_read_data", rd, 32'hCAFE_F00D);
      xfer(1, 4'b0010, 32'h0000_5500, BASE + 32'h8, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("rl3_rmw_latency", e, 6);
      chk("rl3_rmw_din0", ld, 32'hCAFE_550D);
      xfer(0, 4'hF, 32'h0, BASE + 32'h8, e, n0, n1, ld, la0, la1, ge, ga, aft);
      chk("rl3_rmw_readback", rd, 32'hCAFE_550D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
